// File: rtl/actor_pkg.sv
// Shared definitions for the actor movement scheduler: direction codes,
// the sequencer state encoding and the tile coordinate width.
package actor_pkg;

  localparam int TILE_W = 5;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    LOOKUP = 2'd2,
    COMMIT = 2'd3
  } state_t;

endpackage

// File: rtl/tile_step.sv
// Combinational single-tile step: applies a direction to a tile position
// (coordinates wrap modulo 32) and tests the result against the maze border.
module tile_step
  import actor_pkg::*;
#(
  parameter int BORDER_X_MIN = 1,
  parameter int BORDER_X_MAX = 28,
  parameter int BORDER_Y_MIN = 1,
  parameter int BORDER_Y_MAX = 28
) (
  input  logic [TILE_W-1:0] x,
  input  logic [TILE_W-1:0] y,
  input  logic [1:0]        dir,
  output logic [TILE_W-1:0] next_x,
  output logic [TILE_W-1:0] next_y,
  output logic              in_bounds
);

  // Next tile; a step left from x=0 wraps to 31 and is then rejected by the border test.
  always_comb begin
    next_x = x;
    next_y = y;
    case (dir)
      DIR_UP:    next_y = y - TILE_W'(1);
      DIR_LEFT:  next_x = x - TILE_W'(1);
      DIR_DOWN:  next_y = y + TILE_W'(1);
      default:   next_x = x + TILE_W'(1);
    endcase
  end

  // Strict inequalities: the border tiles themselves are never entered.
  always_comb begin
    in_bounds = (next_x > TILE_W'(BORDER_X_MIN)) && (next_x < TILE_W'(BORDER_X_MAX)) &&
                (next_y > TILE_W'(BORDER_Y_MIN)) && (next_y < TILE_W'(BORDER_Y_MAX));
  end

endmodule

// File: rtl/actor_move_scheduler.sv
// Frame-synchronous movement scheduler. Every TICK_FRAMES frames it walks the
// actors in order, asks the shared wall map about each candidate tile and
// commits or blocks the move. Owns all actor tile positions.
module actor_move_scheduler
  import actor_pkg::*;
#(
  parameter int N_ACTORS     = 4,
  parameter int TICK_FRAMES  = 8,
  parameter int VBLANK_LINE  = 480,
  parameter int BORDER_X_MIN = 1,
  parameter int BORDER_X_MAX = 28,
  parameter int BORDER_Y_MIN = 1,
  parameter int BORDER_Y_MAX = 28,
  parameter int START_X      = 2,
  parameter int START_Y      = 2,
  parameter int ACK_TIMEOUT  = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [9:0]            shpos,
  input  logic [9:0]            svpos,
  input  logic [2*N_ACTORS-1:0] dir_in,
  input  logic                  wall_ack,
  input  logic                  wall_hit,
  output logic                  wall_req,
  output logic [4:0]            wall_x,
  output logic [4:0]            wall_y,
  output logic [5*N_ACTORS-1:0] xpos_flat,
  output logic [5*N_ACTORS-1:0] ypos_flat,
  output logic [2:0]            cur_actor,
  output logic                  anim_state,
  output logic                  busy,
  output logic [N_ACTORS-1:0]   moved,
  output logic                  round_done,
  output logic                  overrun
);

  localparam int FW = (TICK_FRAMES > 1) ? $clog2(TICK_FRAMES) : 1;
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

  state_t              state_reg, state_next;
  logic [FW-1:0]       frame_cnt_reg;
  logic [TW-1:0]       to_cnt_reg;
  logic [2:0]          cur_actor_reg;
  logic                busy_reg, overrun_reg, anim_reg, round_done_reg;
  logic                wall_req_reg, blocked_reg;
  logic [TILE_W-1:0]   wall_x_reg, wall_y_reg;

  // Per-actor views padded to 8 entries so cur_actor can index them directly.
  logic [7:0][TILE_W-1:0] x_all, y_all;
  logic [7:0][1:0]        dir_all;

  logic [TILE_W-1:0] step_x, step_y;
  logic              step_in_bounds;
  logic              trigger, frame_wrap, start_round;
  logic              ack_timeout, last_actor, commit_move;

  assign trigger     = (svpos == 10'(VBLANK_LINE)) && (shpos == 10'd0);
  assign frame_wrap  = (frame_cnt_reg == FW'(TICK_FRAMES - 1));
  assign start_round = trigger && frame_wrap && !busy_reg;
  assign ack_timeout = (to_cnt_reg == TW'(ACK_TIMEOUT - 1));
  assign last_actor  = (cur_actor_reg == 3'(N_ACTORS - 1));
  assign commit_move = (state_reg == COMMIT) && !blocked_reg;

  tile_step #(
    .BORDER_X_MIN (BORDER_X_MIN),
    .BORDER_X_MAX (BORDER_X_MAX),
    .BORDER_Y_MIN (BORDER_Y_MIN),
    .BORDER_Y_MAX (BORDER_Y_MAX)
  ) u_step (
    .x         (x_all[cur_actor_reg]),
    .y         (y_all[cur_actor_reg]),
    .dir       (dir_all[cur_actor_reg]),
    .next_x    (step_x),
    .next_y    (step_y),
    .in_bounds (step_in_bounds)
  );

  // Position storage, one register pair per actor; only COMMIT of a free move writes it.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_actor
      if (gi < N_ACTORS) begin : g_live
        logic [TILE_W-1:0] x_reg, y_reg;
        logic              moved_reg;
        logic              sel;
        assign sel = commit_move && (cur_actor_reg == 3'(gi));

        // Commit the looked-up tile and raise the one-cycle moved flag.
        always_ff @(posedge clk) begin
          if (reset) begin
            x_reg     <= TILE_W'(START_X + 4 * gi);
            y_reg     <= TILE_W'(START_Y);
            moved_reg <= 1'b0;
          end else begin
            moved_reg <= sel;
            if (sel) begin
              x_reg <= wall_x_reg;
              y_reg <= wall_y_reg;
            end
          end
        end

        assign x_all[gi]               = x_reg;
        assign y_all[gi]               = y_reg;
        assign dir_all[gi]             = dir_in[2*gi +: 2];
        assign xpos_flat[5*gi +: 5]    = x_reg;
        assign ypos_flat[5*gi +: 5]    = y_reg;
        assign moved[gi]               = moved_reg;
      end else begin : g_pad
        assign x_all[gi]   = '0;
        assign y_all[gi]   = '0;
        assign dir_all[gi] = '0;
      end
    end
  endgenerate

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state selection for the per-actor CALC/LOOKUP/COMMIT walk.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_round) state_next = CALC;
      CALC:    state_next = step_in_bounds ? LOOKUP : COMMIT;
      LOOKUP:  if (wall_ack || ack_timeout) state_next = COMMIT;
      COMMIT:  state_next = last_actor ? IDLE : CALC;
      default: state_next = IDLE;
    endcase
  end

  // Frame divider: advances on every trigger, even while a round is running.
  always_ff @(posedge clk) begin
    if (reset)        frame_cnt_reg <= '0;
    else if (trigger) frame_cnt_reg <= frame_wrap ? '0 : frame_cnt_reg + 1'b1;
  end

  // Round control, wall-map handshake and per-actor outcome registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_reg       <= 1'b0;
      overrun_reg    <= 1'b0;
      anim_reg       <= 1'b0;
      round_done_reg <= 1'b0;
      cur_actor_reg  <= '0;
      wall_req_reg   <= 1'b0;
      wall_x_reg     <= '0;
      wall_y_reg     <= '0;
      blocked_reg    <= 1'b0;
      to_cnt_reg     <= '0;
    end else begin
      round_done_reg <= 1'b0;
      // busy stays up through the round_done cycle and drops right after it.
      if (start_round) begin
        busy_reg      <= 1'b1;
        cur_actor_reg <= '0;
      end else if (round_done_reg) begin
        busy_reg <= 1'b0;
      end
      if (trigger && busy_reg) overrun_reg <= 1'b1;

      case (state_reg)
        CALC: begin
          blocked_reg <= !step_in_bounds;
          if (step_in_bounds) begin
            wall_x_reg   <= step_x;
            wall_y_reg   <= step_y;
            wall_req_reg <= 1'b1;
            to_cnt_reg   <= '0;
          end
        end
        LOOKUP: begin
          if (wall_ack) begin
            blocked_reg  <= wall_hit;
            wall_req_reg <= 1'b0;
          end else if (ack_timeout) begin
            blocked_reg  <= 1'b1;
            wall_req_reg <= 1'b0;
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
        end
        COMMIT: begin
          if (last_actor) begin
            anim_reg       <= ~anim_reg;
            round_done_reg <= 1'b1;
            cur_actor_reg  <= '0;
          end else begin
            cur_actor_reg <= cur_actor_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign wall_req   = wall_req_reg;
  assign wall_x     = wall_x_reg;
  assign wall_y     = wall_y_reg;
  assign cur_actor  = cur_actor_reg;
  assign anim_state = anim_reg;
  assign busy       = busy_reg;
  assign round_done = round_done_reg;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_actor_move_scheduler.sv
// Scoreboard bench for actor_move_scheduler: stimulus pushes expected lookups
// and round results from a tile-level reference model; a monitor checks them.
module tb_actor_move_scheduler;

  localparam int N    = 4;
  localparam int TICK = 2;
  localparam int VBL  = 480;
  localparam int TMO  = 15;

  logic        clk, reset;
  logic [9:0]  shpos, svpos;
  logic [7:0]  dir_in;
  logic        wall_ack, wall_hit, wall_req;
  logic [4:0]  wall_x, wall_y;
  logic [19:0] xpos_flat, ypos_flat;
  logic [2:0]  cur_actor;
  logic        anim_state, busy, round_done, overrun;
  logic [3:0]  moved;

  actor_move_scheduler #(.N_ACTORS(N), .TICK_FRAMES(TICK), .VBLANK_LINE(VBL)) dut (
    .clk(clk), .reset(reset), .shpos(shpos), .svpos(svpos), .dir_in(dir_in),
    .wall_ack(wall_ack), .wall_hit(wall_hit), .wall_req(wall_req),
    .wall_x(wall_x), .wall_y(wall_y), .xpos_flat(xpos_flat), .ypos_flat(ypos_flat),
    .cur_actor(cur_actor), .anim_state(anim_state), .busy(busy), .moved(moved),
    .round_done(round_done), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int a; logic [4:0] x; logic [4:0] y; int len; } lookup_t;
  typedef struct { logic [19:0] xf; logic [19:0] yf; logic anim; logic [3:0] mask; } round_t;
  typedef struct { int d; logic h; } plan_t;

  lookup_t exp_lookup_q[$];
  round_t  exp_round_q[$];
  plan_t   plan_q[$];

  int   total_cnt = 0, passed_cnt = 0;
  int   mx[N], my[N];
  logic m_anim;
  int   fc;
  int   rounds_pushed = 0, rounds_seen = 0;
  logic [1:0] tb_dir[N];
  int   plan_d[N];
  logic plan_h[N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) passed_cnt++;
    else $display("FAIL %s: got %0d required %0d", name, act, req);
  endtask

  task automatic fail_now(input string name);
    total_cnt++;
    $display("FAIL %s: got event-missing required event", name);
  endtask

  task automatic summary();
    $display("%0d/%0d checks passed", passed_cnt, total_cnt);
  endtask

  // Reference rule: one tile in the given direction, modulo 32, strict border box.
  function automatic void model_step(input logic [1:0] d, input int x, input int y,
                                     output int nx, output int ny, output bit ok);
    nx = x; ny = y;
    case (d)
      2'd0:    ny = (y + 31) % 32;
      2'd1:    nx = (x + 31) % 32;
      2'd2:    ny = (y + 1) % 32;
      default: nx = (x + 1) % 32;
    endcase
    ok = (nx > 1) && (nx < 28) && (ny > 1) && (ny < 28);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin mx[i] = 2 + 4 * i; my[i] = 2; end
    m_anim = 1'b0;
    fc = 0;
  endtask

  task automatic push_round();
    round_t r;
    lookup_t l;
    plan_t p;
    int nx, ny;
    bit ok, blk;
    r.mask = '0;
    for (int i = 0; i < N; i++) begin
      model_step(tb_dir[i], mx[i], my[i], nx, ny, ok);
      if (ok) begin
        l.a = i; l.x = 5'(nx); l.y = 5'(ny);
        l.len = (plan_d[i] > TMO) ? TMO : plan_d[i];
        exp_lookup_q.push_back(l);
        p.d = plan_d[i]; p.h = plan_h[i];
        plan_q.push_back(p);
        blk = (plan_d[i] > TMO) ? 1'b1 : plan_h[i];
        if (!blk) begin mx[i] = nx; my[i] = ny; r.mask[i] = 1'b1; end
      end
    end
    m_anim = ~m_anim;
    r.anim = m_anim;
    for (int i = 0; i < N; i++) begin
      r.xf[5*i +: 5] = 5'(mx[i]);
      r.yf[5*i +: 5] = 5'(my[i]);
    end
    exp_round_q.push_back(r);
    rounds_pushed++;
  endtask

  task automatic set_dirs();
    dir_in = {tb_dir[3], tb_dir[2], tb_dir[1], tb_dir[0]};
  endtask

  task automatic trigger(input bit expect_busy);
    @(posedge clk); #1;
    if (fc == TICK - 1) begin
      fc = 0;
      if (!expect_busy) push_round();
    end else begin
      fc++;
    end
    svpos = 10'(VBL); shpos = 10'd0;
    @(posedge clk); #1;
    svpos = 10'd0; shpos = 10'd5;
  endtask

  task automatic wait_rounds();
    for (int i = 0; i < 600 && rounds_seen < rounds_pushed; i++) @(posedge clk);
    if (rounds_seen < rounds_pushed) fail_now("round_timeout");
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    exp_lookup_q.delete(); exp_round_q.delete(); plan_q.delete();
    model_reset();
    rounds_pushed = rounds_seen;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic set_all(input logic [1:0] d, input int dly, input logic h);
    for (int i = 0; i < N; i++) begin tb_dir[i] = d; plan_d[i] = dly; plan_h[i] = h; end
    set_dirs();
  endtask

  // Wall-map responder: answers each request after its planned delay, emits stray acks otherwise.
  initial begin : responder
    int rc;
    plan_t p;
    rc = 0; p.d = 1; p.h = 1'b0;
    wall_ack = 1'b0; wall_hit = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (reset || !wall_req) begin
        rc = 0;
        wall_ack = !reset && ($urandom_range(0, 3) == 0);
        wall_hit = 1'($urandom_range(0, 1));
      end else begin
        rc++;
        if (rc == 1) begin
          if (plan_q.size() > 0) p = plan_q.pop_front();
          else begin p.d = 1; p.h = 1'b0; end
        end
        wall_ack = (rc == p.d);
        wall_hit = (rc == p.d) ? p.h : 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: compares lookups and round results against the scoreboard queues.
  initial begin : monitor
    logic prev_req;
    int len;
    logic [3:0] mask;
    bit have_l;
    lookup_t l;
    round_t r;
    prev_req = 1'b0; len = 0; mask = '0; have_l = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_req = 1'b0; len = 0; mask = '0; have_l = 0;
      end else begin
        mask |= moved;
        if (wall_req && !prev_req) begin
          len = 0;
          if (exp_lookup_q.size() > 0) begin
            l = exp_lookup_q.pop_front();
            have_l = 1;
            $display("lookup actor=%0d x=%0d y=%0d", cur_actor, wall_x, wall_y);
            check("lookup_actor", 32'(cur_actor), 32'(l.a));
            check("lookup_x", 32'(wall_x), 32'(l.x));
            check("lookup_y", 32'(wall_y), 32'(l.y));
          end else begin
            fail_now("lookup_unexpected");
          end
        end
        if (wall_req) len++;
        if (!wall_req && prev_req && have_l) begin
          check("req_len", 32'(len), 32'(l.len));
          have_l = 0;
        end
        prev_req = wall_req;
        if (round_done) begin
          rounds_seen++;
          if (exp_round_q.size() > 0) begin
            r = exp_round_q.pop_front();
            $display("round x=%05h y=%05h anim=%0d moved=%b", xpos_flat, ypos_flat, anim_state, mask);
            check("round_xpos", 32'(xpos_flat), 32'(r.xf));
            check("round_ypos", 32'(ypos_flat), 32'(r.yf));
            check("round_anim", 32'(anim_state), 32'(r.anim));
            check("round_moved", 32'(mask), 32'(r.mask));
            check("busy_at_done", 32'(busy), 32'd1);
          end else begin
            fail_now("round_unexpected");
          end
          mask = '0;
        end
      end
    end
  end

  initial begin : watchdog
    repeat (80000) @(posedge clk);
    fail_now("watchdog");
    summary();
    $finish;
  end

  initial begin : stimulus
    reset = 1'b1; svpos = 10'd0; shpos = 10'd5; dir_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_xpos", 32'(xpos_flat), 32'({5'd14, 5'd10, 5'd6, 5'd2}));
    check("reset_ypos", 32'(ypos_flat), 32'({5'd2, 5'd2, 5'd2, 5'd2}));
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_anim", 32'(anim_state), 32'd0);
    check("reset_req", 32'(wall_req), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);

    // Two rounds of everyone moving right with immediate clear acks.
    set_all(2'd3, 1, 1'b0);
    trigger(0);
    @(negedge clk);
    check("no_start_first_trigger", 32'(busy), 32'd0);
    trigger(0);
    @(negedge clk);
    check("busy_after_start", 32'(busy), 32'd1);
    wait_rounds();
    trigger(0); trigger(0);
    wait_rounds();

    // Border block, wall hit after 3 cycles, clear move, top border block.
    do_reset();
    tb_dir[0] = 2'd1; tb_dir[1] = 2'd2; tb_dir[2] = 2'd3; tb_dir[3] = 2'd0;
    plan_d[1] = 3; plan_h[1] = 1'b1; plan_d[2] = 2; plan_h[2] = 1'b0;
    set_dirs();
    trigger(0); trigger(0);
    wait_rounds();

    // Actor 0 never acknowledged; boundary ack exactly on the last allowed cycle.
    set_all(2'd3, 1, 1'b0);
    plan_d[0] = 99; plan_d[1] = TMO; plan_h[1] = 1'b0;
    trigger(0); trigger(0);
    wait_rounds();

    // Trigger during a long round: sticky overrun, frame counter still advances.
    set_all(2'd2, 99, 1'b0);
    trigger(0); trigger(0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("overrun_before", 32'(overrun), 32'd0);
    trigger(1);
    @(negedge clk);
    check("overrun_set", 32'(overrun), 32'd1);
    wait_rounds();
    set_all(2'd0, 2, 1'b0);
    trigger(0);
    wait_rounds();
    check("overrun_sticky", 32'(overrun), 32'd1);

    // Reset while a lookup is outstanding.
    set_all(2'd3, 99, 1'b0);
    trigger(0); trigger(0);
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
        @(negedge clk);
        if (wall_req) seen = 1;
      end
      if (!seen) fail_now("req_never_rose");
    end
    repeat (3) @(posedge clk);
    do_reset();
    @(negedge clk);
    check("rst_mid_req", 32'(wall_req), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_xpos", 32'(xpos_flat), 32'({5'd14, 5'd10, 5'd6, 5'd2}));
    check("rst_mid_ypos", 32'(ypos_flat), 32'({5'd2, 5'd2, 5'd2, 5'd2}));
    check("rst_mid_overrun", 32'(overrun), 32'd0);
    check("rst_mid_anim", 32'(anim_state), 32'd0);
    repeat (30) @(posedge clk);

    // Random rounds.
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < N; i++) begin
        tb_dir[i] = 2'($urandom_range(0, 3));
        plan_d[i] = $urandom_range(1, 17);
        plan_h[i] = ($urandom_range(0, 3) == 0);
      end
      set_dirs();
      trigger(0); trigger(0);
      wait_rounds();
    end

    repeat (10) @(posedge clk);
    check("lookups_drained", 32'(exp_lookup_q.size()), 32'd0);
    check("rounds_drained", 32'(exp_round_q.size()), 32'd0);
    summary();
    $finish;
  end

endmodule
